lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
- Multi-cycle load/store sequencer between the RV32I single-cycle core and data memory.
- Accepts one load or store command from control, using the decoder's func3 and the ALU's effective address.
- Runs a req/ack handshake to a word-addressed memory and generates byte enables and store-data lane replication.
- Extracts and sign/zero-extends load data, and stalls the core while a transfer is outstanding.

Parameters:
- TIMEOUT, 16: max cycles mem_req may stay high without mem_ack before an error is raised (only with LSU_TIMEOUT_EN).
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_load  in  1  one-cycle load command; sampled only in IDLE.
- start_store  in  1  one-cycle store command; sampled only in IDLE.
- func3  in  3  RV32I width/sign code, from the decoder.
- addr  in  32  effective byte address.
- store_data  in  32  rs2 value.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, {addr[31:2],2'b00}.
- mem_be  out  4  byte enables; 4'b1111 for loads.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory completion strobe.
- mem_rdata  in  32  read word, valid when mem_ack=1.
- load_data  out  32  extended load result, registered.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse, coincident with done.
- busy  out  1  core stall; high whenever state != IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE; mem_req, mem_we, done, err=0; mem_addr, mem_be, mem_wdata, load_data=0; counter=0. Reset mid-transfer drops mem_req immediately.
- States: IDLE, REQ, DONE, ERR.
- IDLE -> ERR when any of these holds at the edge:
  - start_load and start_store both high;
  - illegal func3 (load: 011/110/111; store: anything other than 000/001/010);
  - misalignment: half requires addr[0]=0, word requires addr[1:0]=0.
- IDLE -> REQ on a legal start. At that edge, latch op, func3 and addr[1:0]; drive mem_addr, mem_we, mem_be and mem_wdata. No memory request is issued on error.
- REQ:
  - mem_req=1 with address, data and enables held stable.
  - On mem_ack=1: a load registers the extended result into load_data; go to DONE.
  - Minimum latency, start to done: 2 cycles (ack in first REQ cycle).
- DONE: done=1 for one cycle; mem_req=0; go to IDLE. A new start is accepted in the following IDLE cycle, not in DONE.
- ERR: done=1 and err=1 for one cycle; load_data unchanged; go to IDLE.
- Starts asserted outside IDLE are ignored. mem_ack outside REQ is ignored.
- Store enables and data, with lane = addr[1:0]:
  - SB: mem_be = 4'b0001<<lane; mem_wdata = {4{store_data[7:0]}}.
  - SH: mem_be = addr[1] ? 4'b1100 : 4'b0011; mem_wdata = {2{store_data[15:0]}}.
  - SW: mem_be = 4'b1111; mem_wdata = store_data.
- Load extraction from mem_rdata:
  - LB/LBU: byte at bits [8*lane+7 : 8*lane], sign- or zero-extended.
  - LH/LHU: half selected by addr[1], sign- or zero-extended.
  - LW: full word.
- busy is combinational from state, so it is high in REQ, DONE and ERR.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - The counter clears on entering REQ and increments each REQ cycle without ack.
  - When the counter reaches TIMEOUT with no ack: mem_req drops and the FSM goes to ERR.
  - If ack arrives in the same cycle the count reaches TIMEOUT, ack wins (DONE).
- Not defined: no counter is built; REQ waits for mem_ack indefinitely; err is raised only by illegal or misaligned commands.

Test Plan:
- LB at addr=0x1003, mem_rdata=0x80FF_1234 acked in 1st REQ cycle -> mem_addr=0x1000, mem_be=4'b1111, load_data=0xFFFF_FF80, done 2 cycles after start, busy high for 2 cycles.
- LHU at addr=0x2002, mem_rdata=0xBEEF_0000 with ack delayed 3 cycles -> mem_req held for 4 cycles with stable addr; load_data=0x0000_BEEF; done pulse of 1 cycle.
- SB addr=0x10, store_data=0x1234_56AB then SH addr=0x12, store_data=0xCAFE -> mem_be=0001, wdata=0xABAB_ABAB, we=1; then mem_be=1100, wdata=0xCAFE_CAFE.
- Error cases -> err=done=1 one cycle after start, mem_req never asserted:
  - LW addr=0x6;
  - load func3=3'b011;
  - start_load and start_store together.
- Reset mid-REQ: rst low 2 cycles into an unacked request -> mem_req=0 asynchronously; after release, state IDLE, busy=0, and a fresh LW completes normally.
- With LSU_TIMEOUT_EN and TIMEOUT=16, no ack -> mem_req high for 16 cycles then err=done=1; ack on the 16th cycle -> done with err=0.

Source files
------------

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - RV32I load/store sequencer with req/ack memory handshake; optional request timeout under LSU_TIMEOUT_EN
module lsu_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_load,
    input  logic        start_store,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] load_data,
    output logic        done,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t      state;
    logic        op_load;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;

    logic        any_start;
    logic        both_start;
    logic        f3_bad;
    logic        misaligned;
    logic        cmd_bad;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    // The counter has to be able to represent TIMEOUT.
    if ((2 ** CNT_W) <= TIMEOUT) begin : g_cnt_w_check
        $error("lsu_ctrl: CNT_W too narrow for TIMEOUT");
    end

`ifdef LSU_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
`endif

    // Pick the byte/half/word out of the read word and extend it.
    function automatic logic [31:0] extend_load(
        input logic [2:0]  f3,
        input logic [1:0]  lane,
        input logic [31:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] shifted;
        shifted = word >> {lane, 3'b000};
        b       = shifted[7:0];
        h       = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  extend_load = {{24{b[7]}}, b};
            3'b100:  extend_load = {24'h0, b};
            3'b001:  extend_load = {{16{h[15]}}, h};
            3'b101:  extend_load = {16'h0, h};
            default: extend_load = word;
        endcase
    endfunction

    // Command legality and store lane steering, evaluated against the live inputs in IDLE.
    always_comb begin
        any_start  = start_load | start_store;
        both_start = start_load & start_store;
        if (start_load) begin
            f3_bad = (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111);
        end else begin
            f3_bad = func3[2] || (func3[1:0] == 2'b11);
        end
        misaligned = ((func3[1:0] == 2'b01) && addr[0]) ||
                     ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        cmd_bad    = both_start | f3_bad | misaligned;
        case (func3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << addr[1:0];
                st_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                st_be    = addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{store_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = store_data;
            end
        endcase
    end

    // Stall the core for every non-IDLE state.
    assign busy = (state != IDLE);

    // Sequencer: accepts a command in IDLE, holds the request until ack, then pulses done/err.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
            load_data <= 32'h0;
            done      <= 1'b0;
            err       <= 1'b0;
            op_load   <= 1'b0;
            f3_q      <= 3'b000;
            lane_q    <= 2'b00;
`ifdef LSU_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_start) begin
                        if (cmd_bad) begin
                            state <= ERR;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            op_load   <= start_load;
                            f3_q      <= func3;
                            lane_q    <= addr[1:0];
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_we    <= start_store;
                            mem_be    <= start_load ? 4'b1111 : st_be;
                            mem_wdata <= start_load ? 32'h0 : st_wdata;
`ifdef LSU_TIMEOUT_EN
                            cnt       <= '0;
`endif
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (op_load) begin
                            load_data <= extend_load(f3_q, lane_q, mem_rdata);
                        end
                        state <= DONE;
                        done  <= 1'b1;
                    end
`ifdef LSU_TIMEOUT_EN
                    // Ack is checked first so an ack on the final allowed cycle still completes.
                    else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        mem_req <= 1'b0;
                        cnt     <= cnt + 1'b1;
                        state   <= ERR;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
